// File: rtl/spi_modport_pkg.sv
// Shared types and constants for the spi_modport SPI slave.
package spi_modport_pkg;

   localparam int unsigned CNT_W = $clog2(33);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

endpackage

// File: rtl/spi_modport_sync.sv
// Two-flop synchronizer with rise/fall strobes derived from the synchronized level.
module spi_modport_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise_c,
   output logic fall_c
);

   logic meta;
   logic prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
         prev <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
         prev <= q;
      end
   end

   assign rise_c = q & ~prev;
   assign fall_c = ~q & prev;

endmodule

// File: rtl/spi_modport.sv
// SPI slave: oversampled sclk/ss/mosi, configurable edges and bit order.
// Optional frame_err output enabled by defining SPI_MODPORT_FRAME_ERR_EN.
module spi_modport
   import spi_modport_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned SS_IDX = 0,
   parameter int unsigned RX_NEG = 0,
   parameter int unsigned TX_NEG = 1,
   parameter int unsigned LSB    = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       ss_pad_o,
   input  logic              sclk_pad_o,
   input  logic              mosi_pad_o,
   output logic              miso_pad_i,
   input  logic [DATA_W-1:0] tx_data,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
`ifdef SPI_MODPORT_FRAME_ERR_EN
   output logic              frame_err,
`endif
   output logic              busy
);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] rx_sr;
   logic [DATA_W-1:0] tx_sr;
   logic [DATA_W-1:0] rx_next;
   logic [DATA_W-1:0] tx_shifted;
   logic [2:0]        arm;

   logic sclk_q, sclk_rise_c, sclk_fall_c;
   logic sel_q, sel_fall_c, sel_rise_unused;
   logic mosi_q, mosi_rise_unused, mosi_fall_unused;
   logic sample_c, shift_c, word_end_c;
   logic ss_unused;

   // Only ss_pad_o[SS_IDX] selects this slave; the remaining bits are don't-care.
   assign ss_unused = ^ss_pad_o;

   spi_modport_sync #(.RST_VAL(1'b0)) u_sclk_sync (
      .clk(clk), .rst(rst), .d(sclk_pad_o),
      .q(sclk_q), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
   );

   spi_modport_sync #(.RST_VAL(1'b1)) u_sel_sync (
      .clk(clk), .rst(rst), .d(ss_pad_o[SS_IDX]),
      .q(sel_q), .rise_c(sel_rise_unused), .fall_c(sel_fall_c)
   );

   spi_modport_sync #(.RST_VAL(1'b0)) u_mosi_sync (
      .clk(clk), .rst(rst), .d(mosi_pad_o),
      .q(mosi_q), .rise_c(mosi_rise_unused), .fall_c(mosi_fall_unused)
   );

   function automatic logic first_bit(input logic [DATA_W-1:0] w);
      return (LSB != 0) ? w[0] : w[DATA_W-1];
   endfunction

   assign sample_c   = (RX_NEG != 0) ? sclk_fall_c : sclk_rise_c;
   assign shift_c    = (TX_NEG != 0) ? sclk_fall_c : sclk_rise_c;
   assign word_end_c = sample_c && (cnt == CNT_W'(DATA_W - 1));

   always_comb begin
      rx_next    = (LSB != 0) ? (rx_sr >> 1) : (rx_sr << 1);
      tx_shifted = (LSB != 0) ? (tx_sr >> 1) : (tx_sr << 1);
      if (LSB != 0) rx_next[DATA_W-1] = mosi_q;
      else          rx_next[0]        = mosi_q;
   end

   // arm blocks the false select fall produced when the preset synchronizer
   // flushes after reset, so a new frame needs a genuine select falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         rx_sr      <= '0;
         tx_sr      <= '0;
         miso_pad_i <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         busy       <= 1'b0;
         arm        <= '0;
`ifdef SPI_MODPORT_FRAME_ERR_EN
         frame_err  <= 1'b0;
`endif
      end else begin
         rx_valid <= 1'b0;
         arm      <= {arm[1:0], 1'b1};
`ifdef SPI_MODPORT_FRAME_ERR_EN
         frame_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               miso_pad_i <= 1'b0;
               busy       <= 1'b0;
               cnt        <= '0;
               if (sel_fall_c && arm[2]) begin
                  state      <= SHIFT;
                  tx_sr      <= tx_data;
                  miso_pad_i <= first_bit(tx_data);
               end
            end
            SHIFT: begin
               if (sel_q) begin
                  state      <= IDLE;
                  cnt        <= '0;
                  miso_pad_i <= 1'b0;
                  busy       <= 1'b0;
`ifdef SPI_MODPORT_FRAME_ERR_EN
                  frame_err  <= (cnt != '0);
`endif
               end else begin
                  if (shift_c && cnt != '0) begin
                     tx_sr      <= tx_shifted;
                     miso_pad_i <= first_bit(tx_shifted);
                  end
                  if (sample_c) begin
                     rx_sr <= rx_next;
                     if (word_end_c) begin
                        cnt        <= '0;
                        busy       <= 1'b0;
                        rx_data    <= rx_next;
                        rx_valid   <= 1'b1;
                        tx_sr      <= tx_data;
                        miso_pad_i <= first_bit(tx_data);
                     end else begin
                        cnt  <= cnt + CNT_W'(1);
                        busy <= 1'b1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_modport.sv
// Directed bench for spi_modport: one MSB-first and one LSB-first slave, 8-bit words.
module tb_spi_modport;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ss;
   logic        sclk;
   logic        mosi;
   logic [7:0]  tx_data;
   logic        miso_m, miso_l;
   logic [7:0]  rx_m, rx_l;
   logic        v_m, v_l;
   logic        busy_m, busy_l;
`ifdef SPI_MODPORT_FRAME_ERR_EN
   logic        fe_m, fe_l;
   int          fe_cnt_m = 0;
`endif

   int checks = 0;
   int errors = 0;
   int vcnt_m = 0;
   int vcnt_l = 0;
   int miso_hi = 0;

   logic [7:0] mi_m, mi_l;
   int base_m, base_l, base_hi;

   always #5 clk = ~clk;

   spi_modport #(.DATA_W(8), .SS_IDX(0), .RX_NEG(0), .TX_NEG(1), .LSB(0)) u_msb (
      .clk(clk), .rst(rst), .ss_pad_o(ss), .sclk_pad_o(sclk), .mosi_pad_o(mosi),
      .miso_pad_i(miso_m), .tx_data(tx_data), .rx_data(rx_m), .rx_valid(v_m),
`ifdef SPI_MODPORT_FRAME_ERR_EN
      .frame_err(fe_m),
`endif
      .busy(busy_m)
   );

   spi_modport #(.DATA_W(8), .SS_IDX(0), .RX_NEG(0), .TX_NEG(1), .LSB(1)) u_lsb (
      .clk(clk), .rst(rst), .ss_pad_o(ss), .sclk_pad_o(sclk), .mosi_pad_o(mosi),
      .miso_pad_i(miso_l), .tx_data(tx_data), .rx_data(rx_l), .rx_valid(v_l),
`ifdef SPI_MODPORT_FRAME_ERR_EN
      .frame_err(fe_l),
`endif
      .busy(busy_l)
   );

   always @(posedge clk) begin
      if (v_m) vcnt_m <= vcnt_m + 1;
      if (v_l) vcnt_l <= vcnt_l + 1;
      if (miso_m | miso_l) miso_hi <= miso_hi + 1;
`ifdef SPI_MODPORT_FRAME_ERR_EN
      if (fe_m) fe_cnt_m <= fe_cnt_m + 1;
`endif
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Mode-0 master: mosi changes while sclk low, miso sampled just before sclk rises.
   task automatic xfer(input logic [7:0] mo, input int nbits, input bit lsb_first,
                       output logic [7:0] rm, output logic [7:0] rl);
      rm = '0;
      rl = '0;
      for (int i = 0; i < nbits; i++) begin
         mosi = lsb_first ? mo[i] : mo[7-i];
         wait_clk(8);
         rm = lsb_first ? {miso_m, rm[7:1]} : {rm[6:0], miso_m};
         rl = lsb_first ? {miso_l, rl[7:1]} : {rl[6:0], miso_l};
         sclk = 1'b1;
         wait_clk(8);
         sclk = 1'b0;
      end
   endtask

   task automatic select(input logic [31:0] v);
      ss = v;
      wait_clk(8);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; ss = '1; sclk = 1'b0; mosi = 1'b0; tx_data = 8'h3C;
      wait_clk(3);
      check("reset rx_data", 32'(rx_m), 32'h0);
      check("reset rx_valid", 32'(v_m), 32'h0);
      check("reset busy", 32'(busy_m), 32'h0);
      check("reset miso", 32'(miso_m), 32'h0);
      rst = 1'b0;
      wait_clk(10);

      // MSB-first receive of 0xA5 while transmitting 0x3C
      select(~32'h1);
      xfer(8'hA5, 8, 1'b0, mi_m, mi_l);
      wait_clk(6);
      check("msb rx_data", 32'(rx_m), 32'hA5);
      check("msb rx_valid count", 32'(vcnt_m), 32'd1);
      check("msb miso word", 32'(mi_m), 32'h3C);
      check("msb busy after word", 32'(busy_m), 32'h0);
      select('1);

      // LSB-first single word, then two back-to-back words in one frame
      select(~32'h1);
      xfer(8'h81, 8, 1'b1, mi_m, mi_l);
      wait_clk(6);
      check("lsb rx_data 81", 32'(rx_l), 32'h81);
      check("lsb miso word", 32'(mi_l), 32'h3C);
      select('1);
      base_l = vcnt_l;
      base_m = vcnt_m;
      select(~32'h1);
      xfer(8'h12, 8, 1'b1, mi_m, mi_l);
      check("b2b first miso", 32'(mi_l), 32'h3C);
      xfer(8'h34, 8, 1'b1, mi_m, mi_l);
      wait_clk(6);
      check("b2b second miso", 32'(mi_l), 32'h3C);
      check("b2b rx_valid count", 32'(vcnt_l - base_l), 32'd2);
      check("b2b rx_data", 32'(rx_l), 32'h34);
      check("b2b msb-order rx_data", 32'(rx_m), 32'h2C);
      check("b2b msb valid count", 32'(vcnt_m - base_m), 32'd2);
      select('1);

      // Deselect after 5 bits: partial word discarded
      base_m = vcnt_m;
      select(~32'h1);
      xfer(8'hFF, 5, 1'b0, mi_m, mi_l);
      check("partial busy", 32'(busy_m), 32'h1);
      select('1);
      check("partial no rx_valid", 32'(vcnt_m - base_m), 32'd0);
      check("partial rx_data kept", 32'(rx_m), 32'h2C);
      check("partial busy cleared", 32'(busy_m), 32'h0);
      check("partial miso low", 32'(miso_m), 32'h0);
`ifdef SPI_MODPORT_FRAME_ERR_EN
      check("partial frame_err", 32'(fe_cnt_m), 32'd1);
`endif

      // Another slave selected: this one stays silent
      base_m = vcnt_m;
      base_l = vcnt_l;
      base_hi = miso_hi;
      select(~32'h2);
      xfer(8'hC3, 8, 1'b0, mi_m, mi_l);
      wait_clk(6);
      check("other ss no valid", 32'(vcnt_m - base_m + vcnt_l - base_l), 32'd0);
      check("other ss miso low", 32'(miso_hi - base_hi), 32'd0);
      select('1);

      // Reset in the middle of a word
      base_m = vcnt_m;
      select(~32'h1);
      xfer(8'hF0, 3, 1'b0, mi_m, mi_l);
      rst = 1'b1;
      wait_clk(1);
      check("midrst rx_data", 32'(rx_m), 32'h0);
      check("midrst rx_valid", 32'(v_m), 32'h0);
      check("midrst busy", 32'(busy_m), 32'h0);
      check("midrst miso", 32'(miso_m), 32'h0);
      rst = 1'b0;
      xfer(8'h0F, 5, 1'b0, mi_m, mi_l);
      select('1);
      check("midrst no rx_valid", 32'(vcnt_m - base_m), 32'd0);
      select(~32'h1);
      xfer(8'h5A, 8, 1'b0, mi_m, mi_l);
      wait_clk(6);
      check("post-reset rx_data", 32'(rx_m), 32'h5A);
      check("post-reset valid count", 32'(vcnt_m - base_m), 32'd1);
      check("post-reset miso word", 32'(mi_m), 32'h3C);
      select('1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_modport.md
SPI_MODPORT -- requirements
Module: spi_modport

Interface
REQ-001 SHALL have parameter DATA_W, default 32; word length in bits, legal range 1..32.
REQ-002 SHALL have parameter SS_IDX, default 0; index of the ss_pad_o bit that selects this slave.
REQ-003 SHALL have parameter RX_NEG, default 0; 0 samples MOSI on the sclk rising edge, 1 on the falling edge.
REQ-004 SHALL have parameter TX_NEG, default 1; 0 shifts MISO on the sclk rising edge, 1 on the falling edge.
REQ-005 SHALL have parameter LSB, default 0; 0 transfers MSB first, 1 transfers LSB first.
REQ-006 Port clk, input, 1 bit: one clock; every flop is on its rising edge.
REQ-007 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 Port ss_pad_o, input, 32 bits: master slave-selects, active-low.
REQ-009 Port sclk_pad_o, input, 1 bit: SPI serial clock from the master.
REQ-010 Port mosi_pad_o, input, 1 bit: master-out data.
REQ-011 Port miso_pad_i, output, 1 bit: slave-out data, registered.
REQ-012 Port tx_data, input, DATA_W bits: word to transmit, sampled at the frame/word load.
REQ-013 Port rx_data, output, DATA_W bits: last complete received word, registered.
REQ-014 Port rx_valid, output, 1 bit: one-cycle pulse when rx_data updates.
REQ-015 Port busy, output, 1 bit: high while selected and a word is partially shifted.

Function
REQ-016 SHALL pass sclk_pad_o, mosi_pad_o and ss_pad_o[SS_IDX] through 2-flop synchronizers; sclk period SHALL be ≥4 clk periods.
REQ-017 SHALL detect sclk edges by comparing the synchronized sclk with its previous value: one-cycle rise and fall strobes.
REQ-018 States: IDLE (not selected) and SHIFT (selected); IDLE->SHIFT on synchronized select going low; SHIFT->IDLE on select going high.
REQ-019 On IDLE->SHIFT: load tx_data into the tx shift register, drive the first bit (MSB, or LSB if LSB=1) on miso_pad_i, and clear the bit counter.
REQ-020 On each sample edge per RX_NEG: shift the synchronized MOSI into the rx shift register and increment the bit counter.
REQ-021 On each shift edge per TX_NEG: present the next tx bit on miso_pad_i, except before the first sample of a word.
REQ-022 When the counter reaches DATA_W: copy the rx shift register to rx_data, pulse rx_valid for 1 clk, reset the counter to 0, and reload tx_data if still selected (back-to-back words).
REQ-023 Latency: rx_valid SHALL assert exactly 1 clk after the synchronized edge strobe that samples the final bit.
REQ-024 Deselect mid-word: discard partial data; rx_data unchanged; no rx_valid; counter cleared; miso_pad_i forced to 0.
REQ-025 In IDLE, miso_pad_i SHALL be 0 and sclk edges SHALL be ignored.
REQ-026 Other ss_pad_o bits SHALL have no effect.

Reset
REQ-027 While rst=1 at a clk edge: miso_pad_i=0, rx_data=0, rx_valid=0, busy=0, frame_err=0, counter=0, state=IDLE, synchronizers preset to sclk=0 and select=1.
REQ-028 Reset mid-frame SHALL abort the frame with no rx_valid; a new frame requires a fresh select falling edge.

Configuration
REQ-029 Macro SPI_MODPORT_FRAME_ERR_EN defined: add output frame_err (1 bit), pulsing 1 clk when select deasserts with counter ≠0.
REQ-030 Macro SPI_MODPORT_FRAME_ERR_EN undefined: no frame_err port and no related logic.

Structure
REQ-031 Shared package spi_modport_pkg SHALL hold the state enum (IDLE, SHIFT) and the counter-width constant $clog2(33).
REQ-032 Sub-module spi_modport_sync (2-flop synchronizer plus edge detect) SHALL be instantiated for sclk; the select and MOSI synchronizers SHALL reuse it.

Verification
REQ-033 DATA_W=8, mode defaults, ss[0]=0, MOSI sends 0xA5 MSB-first -> rx_data=0xA5, one rx_valid pulse.
REQ-034 tx_data=0x3C, 8 sclk -> MISO bits sampled by the master on rising edges = 0x3C.
REQ-035 LSB=1, MOSI 0x81 LSB-first -> rx_data=0x81; two back-to-back words 0x12, 0x34 -> two rx_valid pulses, rx_data=0x34.
REQ-036 ss[0] raised after 5 bits -> no rx_valid, rx_data unchanged, frame_err pulse (macro on).
REQ-037 ss[1]=0 only (SS_IDX=0), 8 sclk -> no rx_valid, miso_pad_i=0 throughout.
REQ-038 rst=1 asserted mid-word -> all outputs 0 next cycle; next full frame receives correctly.
